// File: rtl/spi_flash_ctrl.sv
// Single-byte SPI NOR flash controller (mode 0, 24-bit address): READ, or WREN + PAGE PROGRAM + RDSR polling.
// Completion is a one-cycle oDone pulse; oDataOut holds the last byte read.
module spi_flash_ctrl #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int FREQ     = 400_000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iWr,
  input  logic        iRd,
  input  logic [31:0] iAddr,
  input  logic [7:0]  iDataIn,
  output logic [7:0]  oDataOut,
  output logic        oDone,
  output logic        oSpiCs,
  output logic        oSpiClk,
  output logic        oSpiMosi,
  input  logic        iSpiMiso
);

  localparam int HALF_RAW = CLK_FREQ / (2 * FREQ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int DW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(HALF - 1);

  localparam logic [1:0] PH_WREN = 2'd0;
  localparam logic [1:0] PH_PP   = 2'd1;
  localparam logic [1:0] PH_RDSR = 2'd2;

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, DONE} state_t;

  state_t        state_q;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_q, nbits_q, nbits_d;
  logic [39:0]   sh_q, frame_d;
  logic [7:0]    rx_q, data_q;
  logic [23:0]   addr_q;
  logic [1:0]    phase_q;
  logic          is_rd_q;
  logic          rd_q, rd_prev_q, wr_q, wr_prev_q;
  logic          rd_rise, wr_rise, half_hit;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^iAddr[31:24];

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rd_q      <= 1'b0;
      rd_prev_q <= 1'b0;
      wr_q      <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      rd_q      <= iRd;
      rd_prev_q <= rd_q;
      wr_q      <= iWr;
      wr_prev_q <= wr_q;
    end
  end

  assign rd_rise  = rd_q & ~rd_prev_q;
  assign wr_rise  = wr_q & ~wr_prev_q;
  assign half_hit = (div_q == DIV_MAX);
  assign div_d    = div_q + DW'(1);

  // Next frame to launch: from IDLE it is READ or WREN, later frames follow the write phase.
  always_comb begin
    frame_d = {8'h05, 32'h0};
    nbits_d = 6'd16;
    if (state_q == IDLE) begin
      if (rd_rise) begin
        frame_d = {8'h03, iAddr[23:0], 8'h00};
        nbits_d = 6'd40;
      end else begin
        frame_d = {8'h06, 32'h0};
        nbits_d = 6'd8;
      end
    end else if (phase_q == PH_WREN) begin
      frame_d = {8'h02, addr_q, data_q};
      nbits_d = 6'd40;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      nbits_q  <= '0;
      sh_q     <= '0;
      rx_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      phase_q  <= PH_WREN;
      is_rd_q  <= 1'b0;
      oDataOut <= '0;
      oDone    <= 1'b0;
      oSpiCs   <= 1'b1;
      oSpiClk  <= 1'b0;
      oSpiMosi <= 1'b0;
    end else begin
      oDone <= 1'b0;
      div_q <= (half_hit || state_q == IDLE) ? '0 : div_d;
      case (state_q)
        IDLE: begin
          if (rd_rise || wr_rise) begin
            is_rd_q  <= rd_rise;
            phase_q  <= PH_WREN;
            addr_q   <= iAddr[23:0];
            data_q   <= iDataIn;
            sh_q     <= frame_d;
            nbits_q  <= nbits_d;
            bit_q    <= '0;
            oSpiMosi <= frame_d[39];
            oSpiCs   <= 1'b0;
            state_q  <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (half_hit) begin
            oSpiClk <= 1'b1;
            rx_q    <= {rx_q[6:0], iSpiMiso};
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_hit) begin
            if (!oSpiClk) begin
              oSpiClk <= 1'b1;
              rx_q    <= {rx_q[6:0], iSpiMiso};
            end else begin
              oSpiClk <= 1'b0;
              if (bit_q == nbits_q - 6'd1) begin
                state_q <= CS_HOLD;
              end else begin
                bit_q    <= bit_q + 6'd1;
                sh_q     <= {sh_q[38:0], 1'b0};
                oSpiMosi <= sh_q[38];
              end
            end
          end
        end
        CS_HOLD: begin
          if (half_hit) begin
            oSpiCs   <= 1'b1;
            oSpiMosi <= 1'b0;
            state_q  <= GAP;
          end
        end
        GAP: begin
          // rx_q still holds the status byte of the RDSR frame that just ended.
          if (half_hit) begin
            if (is_rd_q || (phase_q == PH_RDSR && !rx_q[0])) begin
              state_q <= DONE;
            end else begin
              phase_q  <= (phase_q == PH_WREN) ? PH_PP : PH_RDSR;
              sh_q     <= frame_d;
              nbits_q  <= nbits_d;
              bit_q    <= '0;
              oSpiMosi <= frame_d[39];
              oSpiCs   <= 1'b0;
              state_q  <= CS_SETUP;
            end
          end
        end
        DONE: begin
          oDone   <= 1'b1;
          if (is_rd_q) oDataOut <= rx_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Scoreboard bench for spi_flash_ctrl: a flash model records each CS frame and answers MISO,
// monitors compare frames and oDone results against expectations queued by the stimulus.
module tb_spi_flash_ctrl;

  localparam int CLK_FREQ = 80;
  localparam int FREQ     = 10;
  localparam int HALF     = 4;

  typedef struct {
    int          n;
    logic [39:0] val;
  } frame_t;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic        iWr = 1'b0;
  logic        iRd = 1'b0;
  logic [31:0] iAddr = '0;
  logic [7:0]  iDataIn = '0;
  logic [7:0]  oDataOut;
  logic        oDone, oSpiCs, oSpiClk, oSpiMosi;
  logic        iSpiMiso;

  spi_flash_ctrl #(.CLK_FREQ(CLK_FREQ), .FREQ(FREQ)) dut (
    .iClk(iClk), .iRst(iRst), .iWr(iWr), .iRd(iRd), .iAddr(iAddr), .iDataIn(iDataIn),
    .oDataOut(oDataOut), .oDone(oDone), .oSpiCs(oSpiCs), .oSpiClk(oSpiClk),
    .oSpiMosi(oSpiMosi), .iSpiMiso(iSpiMiso)
  );

  always #5 iClk = ~iClk;

  int n_tests = 0;
  int n_fail = 0;

  frame_t     exp_frames[$];
  logic [7:0] exp_done[$];
  logic [7:0] status_q[$];
  logic [7:0] rd_byte = '0;
  logic [7:0] exp_dout = '0;

  int          cyc = 0;
  int          fr_n = 0;
  int          frames_seen = 0;
  int          done_seen = 0;
  int          fall_cyc = 0, rise_cyc = 0, last_rise = 0;
  logic        in_frame = 1'b0, have_rise = 1'b0, tbad = 1'b0;
  logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_done = 1'b0;
  logic [63:0] fr_sh = '0;
  logic [7:0]  fr_op = '0, cur_status = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Flash model and monitors, sampled on the falling iClk edge.
  always @(negedge iClk) begin
    cyc++;
    if (!iRst) begin
      in_frame  = 1'b0;
      have_rise = 1'b0;
      prev_cs   = 1'b1;
      prev_sck  = 1'b0;
      prev_done = 1'b0;
      iSpiMiso  = 1'b0;
    end else begin
      if (prev_cs && !oSpiCs) begin
        if (have_rise) chk("cs_gap", 64'((cyc - rise_cyc) >= HALF), 64'd1);
        in_frame = 1'b1;
        fr_n     = 0;
        fr_sh    = '0;
        fr_op    = '0;
        tbad     = 1'b0;
        fall_cyc = cyc;
      end
      if (in_frame && !prev_sck && oSpiClk) begin
        if (fr_n == 0) begin
          if (cyc - fall_cyc != HALF) tbad = 1'b1;
        end else if (cyc - last_rise != 2 * HALF) begin
          tbad = 1'b1;
        end
        last_rise = cyc;
        fr_sh = {fr_sh[62:0], oSpiMosi};
        fr_n++;
        if (fr_n == 8) begin
          fr_op = fr_sh[7:0];
          if (fr_op == 8'h05) cur_status = (status_q.size() > 0) ? status_q.pop_front() : 8'h00;
        end
      end
      if (in_frame && prev_sck && !oSpiClk) begin
        if (fr_op == 8'h03 && fr_n >= 32 && fr_n < 40) iSpiMiso = rd_byte[39 - fr_n];
        else if (fr_op == 8'h05 && fr_n >= 8 && fr_n < 16) iSpiMiso = cur_status[15 - fr_n];
        else iSpiMiso = 1'b0;
      end
      if (in_frame && !prev_cs && oSpiCs) begin
        frame_t e;
        in_frame  = 1'b0;
        have_rise = 1'b1;
        rise_cyc  = cyc;
        iSpiMiso  = 1'b0;
        frames_seen++;
        if (exp_frames.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: got %0d bits %0h, expected no frame", fr_n, fr_sh[39:0]);
        end else begin
          e = exp_frames.pop_front();
          chk("frame_bits", 64'(fr_n), 64'(e.n));
          chk("frame_data", {24'h0, fr_sh[39:0]}, {24'h0, e.val});
          chk("frame_timing", {63'h0, tbad}, 64'd0);
        end
      end
      if (oDone) begin
        done_seen++;
        chk("done_width", {63'h0, prev_done}, 64'd0);
        chk("cs_high_at_done", {63'h0, oSpiCs}, 64'd1);
        if (exp_done.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got oDone with data %0h, expected none", oDataOut);
        end else begin
          chk("done_data", {56'h0, oDataOut}, {56'h0, exp_done.pop_front()});
        end
      end
      prev_cs   = oSpiCs;
      prev_sck  = oSpiClk;
      prev_done = oDone;
    end
  end

  task automatic push_frame(input int n, input logic [39:0] v);
    frame_t f;
    f.n   = n;
    f.val = v;
    exp_frames.push_back(f);
  endtask

  task automatic issue_rd(input logic [31:0] a, input logic [7:0] d, input bit also_wr, input int hold);
    rd_byte  = d;
    exp_dout = d;
    push_frame(40, {8'h03, a[23:0], 8'h00});
    exp_done.push_back(d);
    @(negedge iClk);
    iAddr = a;
    iRd   = 1'b1;
    if (also_wr) iWr = 1'b1;
    if (hold > 0) begin
      repeat (hold) @(negedge iClk);
      iRd = 1'b0;
      iWr = 1'b0;
    end
  endtask

  task automatic issue_wr(input logic [31:0] a, input logic [7:0] d);
    push_frame(8, 40'h06);
    push_frame(40, {8'h02, a[23:0], d});
    status_q.push_back(8'h01);
    push_frame(16, 40'h0500);
    status_q.push_back(8'h00);
    push_frame(16, 40'h0500);
    exp_done.push_back(exp_dout);
    @(negedge iClk);
    iAddr   = a;
    iDataIn = d;
    iWr     = 1'b1;
    repeat (2) @(negedge iClk);
    iWr = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (done_seen >= target) break;
      @(negedge iClk);
    end
    chk("done_timeout", 64'(done_seen >= target), 64'd1);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge iClk);
    chk("rst_cs", {63'h0, oSpiCs}, 64'd1);
    chk("rst_sck", {63'h0, oSpiClk}, 64'd0);
    chk("rst_mosi", {63'h0, oSpiMosi}, 64'd0);
    chk("rst_dout", {56'h0, oDataOut}, 64'd0);
    chk("rst_done", {63'h0, oDone}, 64'd0);
    iRst = 1'b1;
    repeat (2) @(negedge iClk);

    issue_rd(32'h0033_6655, 8'hAA, 1'b0, 2);
    wait_done(1);
    repeat (20) @(negedge iClk);

    issue_wr(32'h0000_0123, 8'hA5);
    wait_done(2);
    repeat (20) @(negedge iClk);

    base = frames_seen;
    issue_rd(32'hFF00_0010, 8'h3C, 1'b0, 0);
    wait_done(3);
    repeat (150) @(negedge iClk);
    iRd = 1'b0;
    chk("held_rd_one_frame", 64'(frames_seen - base), 64'd1);
    repeat (10) @(negedge iClk);

    base = frames_seen;
    issue_rd(32'h000A_BCDE, 8'h5A, 1'b1, 3);
    wait_done(4);
    repeat (150) @(negedge iClk);
    chk("rd_wins_one_frame", 64'(frames_seen - base), 64'd1);

    rd_byte = 8'h99;
    @(negedge iClk);
    iAddr = 32'h0011_1111;
    iRd   = 1'b1;
    repeat (2) @(negedge iClk);
    iRd = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (fr_n >= 12 && in_frame) break;
      @(negedge iClk);
    end
    chk("reached_addr_phase", 64'(fr_n >= 12 && in_frame), 64'd1);
    #2 iRst = 1'b0;
    #1;
    chk("abort_cs", {63'h0, oSpiCs}, 64'd1);
    chk("abort_sck", {63'h0, oSpiClk}, 64'd0);
    chk("abort_done", {63'h0, oDone}, 64'd0);
    repeat (3) @(negedge iClk);
    iRst     = 1'b1;
    exp_dout = 8'h00;
    repeat (3) @(negedge iClk);

    issue_rd(32'h0000_0042, 8'h81, 1'b0, 2);
    wait_done(5);
    repeat (5) @(negedge iClk);

    issue_rd(32'h0000_0000, 8'h00, 1'b0, 2);
    wait_done(6);
    issue_rd(32'h0000_FFFF, 8'hFF, 1'b0, 2);
    wait_done(7);
    repeat (50) @(negedge iClk);

    chk("frames_all_seen", 64'(exp_frames.size()), 64'd0);
    chk("dones_all_seen", 64'(exp_done.size()), 64'd0);
    chk("final_dout", {56'h0, oDataOut}, 64'hFF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
